// File: rtl/gate_vector_sequencer_if.sv
// ---------------------------------------------------------------------------
// gate_vector_sequencer_if
// Bundles the host handshake (start/busy/done/pass/err_count/vec_idx) and the
// gate-under-test connections (a1,b1,a2,b2,c2 out; nor_in,oai_in back) of the
// gate vector sequencer.
//   master : sequencer side (drives gate inputs and host status)
//   slave  : environment side (host plus the gates under test)
// Optional GVS_ERROR_LOG_EN adds first_err_valid/first_err_idx/first_err_obs.
// ---------------------------------------------------------------------------
interface gate_vector_sequencer_if #(
  parameter int ERR_W = 6
);
  logic             start;
  logic             a1;
  logic             b1;
  logic             a2;
  logic             b2;
  logic             c2;
  logic             nor_in;
  logic             oai_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [4:0]       vec_idx;
`ifdef GVS_ERROR_LOG_EN
  logic             first_err_valid;
  logic [4:0]       first_err_idx;
  logic [1:0]       first_err_obs;

  modport master (
    input  start, nor_in, oai_in,
    output a1, b1, a2, b2, c2, busy, done, pass, err_count, vec_idx,
           first_err_valid, first_err_idx, first_err_obs
  );
  modport slave (
    output start, nor_in, oai_in,
    input  a1, b1, a2, b2, c2, busy, done, pass, err_count, vec_idx,
           first_err_valid, first_err_idx, first_err_obs
  );
`else
  modport master (
    input  start, nor_in, oai_in,
    output a1, b1, a2, b2, c2, busy, done, pass, err_count, vec_idx
  );
  modport slave (
    output start, nor_in, oai_in,
    input  a1, b1, a2, b2, c2, busy, done, pass, err_count, vec_idx
  );
`endif
endinterface

// File: rtl/gate_vector_sequencer.sv
// ---------------------------------------------------------------------------
// gate_vector_sequencer
// Steps a 5-bit vector index through NUM_VEC vectors, drives it onto the NOR
// (a1,b1) and OAI (a2,b2,c2) gate inputs, holds each vector HOLD_CYCLES clocks,
// samples the gate outputs once per vector at hold count SAMPLE_OFFSET and
// counts mismatching vectors against a golden model (saturating).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : gate_vector_sequencer_if.master (host handshake + gate signals)
// Optional feature macro: GVS_ERROR_LOG_EN (first-mismatch log outputs).
// ---------------------------------------------------------------------------
module gate_vector_sequencer #(
  parameter int HOLD_CYCLES   = 91,
  parameter int SAMPLE_OFFSET = 80,
  parameter int NUM_VEC       = 32,
  parameter int ERR_W         = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  gate_vector_sequencer_if.master bus
);

  localparam int                CNT_W      = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_SAMPLE = CNT_W'(SAMPLE_OFFSET);
  localparam logic [4:0]        VEC_LAST   = 5'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX    = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       vec_q, vec_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [4:0]       gates_q, gates_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             exp_nor_s, exp_oai_s, miss_s;
`ifdef GVS_ERROR_LOG_EN
  logic             fe_valid_q, fe_valid_d;
  logic [4:0]       fe_idx_q, fe_idx_d;
  logic [1:0]       fe_obs_q, fe_obs_d;
`endif

  // Golden gate model evaluated on the registered gate inputs, so a sample
  // taken on the advance edge still judges the vector being left.
  assign exp_nor_s = ~(gates_q[4] | gates_q[3]);
  assign exp_oai_s = ~((gates_q[2] | gates_q[1]) & gates_q[0]);
  assign miss_s    = (bus.nor_in != exp_nor_s) || (bus.oai_in != exp_oai_s);

  // Next-state, counters, error accounting and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = err_q;
`ifdef GVS_ERROR_LOG_EN
    fe_valid_d = fe_valid_q;
    fe_idx_d   = fe_idx_q;
    fe_obs_d   = fe_obs_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          vec_d   = 5'd0;
          err_d   = '0;
`ifdef GVS_ERROR_LOG_EN
          fe_valid_d = 1'b0;
          fe_idx_d   = 5'd0;
          fe_obs_d   = 2'b00;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_HOLD: begin
        // start is deliberately ignored here: no restart while busy.
        if ((cnt_q == CNT_SAMPLE) && miss_s) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end else begin
            err_d = err_q;
          end
`ifdef GVS_ERROR_LOG_EN
          if (!fe_valid_q) begin
            fe_valid_d = 1'b1;
            fe_idx_d   = vec_q;
            fe_obs_d   = {bus.nor_in, bus.oai_in};
          end else begin
            fe_valid_d = fe_valid_q;
          end
`endif
        end else begin
          err_d = err_q;
        end
        if (cnt_q == CNT_LAST) begin
          if (vec_q == VEC_LAST) begin
            state_d = S_DONE;
          end else begin
            vec_d = vec_q + 5'd1;
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    gates_d = (state_d == S_HOLD) ? vec_d : 5'd0;
    busy_d  = (state_d == S_HOLD);
    done_d  = (state_d == S_DONE);
    pass_d  = (state_d == S_DONE) && (err_d == '0);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= 5'd0;
      err_q   <= '0;
      gates_q <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef GVS_ERROR_LOG_EN
      fe_valid_q <= 1'b0;
      fe_idx_q   <= 5'd0;
      fe_obs_q   <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      gates_q <= gates_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef GVS_ERROR_LOG_EN
      fe_valid_q <= fe_valid_d;
      fe_idx_q   <= fe_idx_d;
      fe_obs_q   <= fe_obs_d;
`endif
    end
  end

  assign {bus.a1, bus.b1, bus.a2, bus.b2, bus.c2} = gates_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.vec_idx   = vec_q;
`ifdef GVS_ERROR_LOG_EN
  assign bus.first_err_valid = fe_valid_q;
  assign bus.first_err_idx   = fe_idx_q;
  assign bus.first_err_obs   = fe_obs_q;
`endif

endmodule
